// File: rtl/operand_entry_ctrl.sv
// Operand-entry / result-capture controller for a 4-bit add/subtract datapath.
// A debounced pushbutton steps through: capture A, capture B + mode, one
// execute cycle that registers the external adder's result, then show.
module operand_entry_ctrl #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic       MAX10_CLK1_50,
    input  logic       RESET_N,
    input  logic       KEY0_N,
    input  logic [4:0] SW,
    input  logic [3:0] adder_sum,
    input  logic       adder_cout,
    output logic [3:0] op_a,
    output logic [3:0] op_b,
    output logic       carry_in,
    output logic [3:0] result,
    output logic       result_cout,
    output logic       result_ovf,
    output logic       result_valid,
    output logic [3:0] LEDR
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {WAIT_RELEASE, ARMED} db_state_t;
    typedef enum logic [1:0] {GET_A, GET_B, EXEC, SHOW} state_t;

    logic          key_meta, key_sync;
    db_state_t     db_state;
    logic [CW-1:0] db_cnt;
    logic          press;
    state_t        state;

    // Two-flop synchronizer; resets to the idle (released) level.
    always_ff @(posedge MAX10_CLK1_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            key_meta <= 1'b1;
            key_sync <= 1'b1;
        end else begin
            key_meta <= KEY0_N;
            key_sync <= key_meta;
        end
    end

    // Debouncer: require a stable release before arming, then a stable
    // press to emit a single registered pulse. Any opposite level restarts.
    always_ff @(posedge MAX10_CLK1_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            db_state <= WAIT_RELEASE;
            db_cnt   <= '0;
            press    <= 1'b0;
        end else begin
            press <= 1'b0;
            case (db_state)
                WAIT_RELEASE: begin
                    if (key_sync) begin
                        if (db_cnt == CNT_LAST) begin
                            db_state <= ARMED;
                            db_cnt   <= '0;
                        end else begin
                            db_cnt <= db_cnt + 1'b1;
                        end
                    end else begin
                        db_cnt <= '0;
                    end
                end
                default: begin
                    if (!key_sync) begin
                        if (db_cnt == CNT_LAST) begin
                            press    <= 1'b1;
                            db_state <= WAIT_RELEASE;
                            db_cnt   <= '0;
                        end else begin
                            db_cnt <= db_cnt + 1'b1;
                        end
                    end else begin
                        db_cnt <= '0;
                    end
                end
            endcase
        end
    end

    // Main sequencer with registered operands, results and one-hot LEDs.
    // Overflow uses the operands as actually driven (B already inverted).
    always_ff @(posedge MAX10_CLK1_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state        <= GET_A;
            op_a         <= '0;
            op_b         <= '0;
            carry_in     <= 1'b0;
            result       <= '0;
            result_cout  <= 1'b0;
            result_ovf   <= 1'b0;
            result_valid <= 1'b0;
            LEDR         <= 4'b0001;
        end else begin
            case (state)
                GET_A: if (press) begin
                    op_a  <= SW[3:0];
                    state <= GET_B;
                    LEDR  <= 4'b0010;
                end
                GET_B: if (press) begin
                    op_b     <= SW[4] ? ~SW[3:0] : SW[3:0];
                    carry_in <= SW[4];
                    state    <= EXEC;
                    LEDR     <= 4'b0100;
                end
                EXEC: begin
                    result       <= adder_sum;
                    result_cout  <= adder_cout;
                    result_ovf   <= (op_a[3] == op_b[3]) && (adder_sum[3] != op_a[3]);
                    result_valid <= 1'b1;
                    state        <= SHOW;
                    LEDR         <= 4'b1000;
                end
                default: if (press) begin
                    op_a         <= SW[3:0];
                    result_valid <= 1'b0;
                    state        <= GET_B;
                    LEDR         <= 4'b0010;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_operand_entry_ctrl.sv
// Randomized bench: stimulus pushes expected adder results into a queue,
// an independent monitor pops them whenever result_valid rises.
module tb_operand_entry_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       key_n = 1'b1;
    logic [4:0] sw = '0;
    logic [3:0] adder_sum;
    logic       adder_cout;
    logic [3:0] op_a, op_b, result, ledr;
    logic       carry_in, result_cout, result_ovf, result_valid;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0] res;
        logic       cout;
        logic       ovf;
    } exp_t;
    exp_t sb[$];

    // Reference-model state
    bit         phase_b = 1'b0;
    int         exp_a = 0;
    logic [3:0] exp_ledr = 4'b0001;
    bit         have_res = 1'b0;
    exp_t       last_res;

    always #5 clk = ~clk;

    assign {adder_cout, adder_sum} = 5'(op_a) + 5'(op_b) + 5'(carry_in);

    operand_entry_ctrl #(.DEBOUNCE_CYCLES(4)) dut (
        .MAX10_CLK1_50(clk), .RESET_N(rst_n), .KEY0_N(key_n), .SW(sw),
        .adder_sum(adder_sum), .adder_cout(adder_cout),
        .op_a(op_a), .op_b(op_b), .carry_in(carry_in),
        .result(result), .result_cout(result_cout), .result_ovf(result_ovf),
        .result_valid(result_valid), .LEDR(ledr)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One clean press with value v; model decides what it means.
    task automatic do_press(input logic [4:0] v);
        exp_t e;
        int a, b, sa, sb2, sr, raw;
        bit m;
        if (phase_b) begin
            a = exp_a; b = int'(v[3:0]); m = v[4];
            raw = m ? a - b : a + b;
            e.res = 4'(raw & 15);
            e.cout = m ? (a >= b) : (raw > 15);
            sa = (a > 7) ? a - 16 : a;
            sb2 = (b > 7) ? b - 16 : b;
            sr = m ? sa - sb2 : sa + sb2;
            e.ovf = (sr > 7) || (sr < -8);
            sb.push_back(e);
        end
        sw = v; key_n = 1'b0;
        cycles(12);
        if (!phase_b) begin
            exp_a = int'(v[3:0]);
            exp_ledr = 4'b0010;
            chk("op_a_capture", op_a, exp_a);
            chk("ledr_get_b", ledr, exp_ledr);
            chk("valid_cleared", result_valid, 0);
            if (have_res) chk("result_held", result, last_res.res);
            phase_b = 1'b1;
        end else begin
            exp_ledr = 4'b1000;
            chk("op_b_capture", op_b, v[4] ? 15 - int'(v[3:0]) : int'(v[3:0]));
            chk("carry_in", carry_in, v[4]);
            chk("ledr_show", ledr, exp_ledr);
            chk("valid_set", result_valid, 1);
            last_res = e; have_res = 1'b1;
            phase_b = 1'b0;
        end
        // SW changes outside a press must not matter.
        sw = 5'($urandom); key_n = 1'b1;
        cycles(12);
    endtask

    // Short low glitches that must never reach the debounce threshold.
    task automatic bounce(input int n);
        logic [3:0] a0;
        a0 = op_a;
        sw = 5'($urandom);
        for (int i = 0; i < n; i++) begin
            key_n = 1'b0; cycles($urandom_range(1, 3));
            key_n = 1'b1; cycles($urandom_range(1, 4));
        end
        cycles(6);
        chk("bounce_ledr", ledr, exp_ledr);
        chk("bounce_op_a", op_a, a0);
    endtask

    // Monitor: every rising result_valid consumes one expectation.
    initial begin
        bit prev_v;
        logic [3:0] prev_l;
        exp_t e;
        prev_v = 1'b0; prev_l = 4'b0001;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_v = 1'b0;
            end else begin
                if (result_valid && !prev_v) begin
                    if (sb.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_result: got result %0h expected none", result);
                    end else begin
                        e = sb.pop_front();
                        chk("result", result, e.res);
                        chk("result_cout", result_cout, e.cout);
                        chk("result_ovf", result_ovf, e.ovf);
                        chk("exec_one_cycle", prev_l, 4'b0100);
                        chk("ledr_at_valid", ledr, 4'b1000);
                    end
                end
                prev_v = result_valid;
            end
            prev_l = ledr;
        end
    end

    initial begin
        logic [4:0] dir_a [4] = '{5'b0_0011, 5'b0_0101, 5'b0_0111, 5'b0_1000};
        logic [4:0] dir_b [4] = '{5'b0_0100, 5'b1_0111, 5'b0_0001, 5'b1_0001};

        // Reset state
        sw = 5'b1_1111;
        cycles(3);
        chk("rst_ledr", ledr, 4'b0001);
        chk("rst_ops", {op_a, op_b, carry_in}, 0);
        chk("rst_result", {result, result_cout, result_ovf, result_valid}, 0);
        rst_n = 1'b1;
        cycles(10);
        chk("idle_ledr", ledr, 4'b0001);

        bounce(5);

        for (int i = 0; i < 4; i++) begin
            do_press(dir_a[i]);
            do_press(dir_b[i]);
        end

        for (int i = 0; i < 10; i++) begin
            if ($urandom_range(0, 1) == 1) bounce($urandom_range(1, 4));
            do_press(5'($urandom));
            if ($urandom_range(0, 1) == 1) bounce($urandom_range(1, 4));
            do_press(5'($urandom));
        end

        // Reset while in GET_B with the key held low
        do_press(5'b0_0110);
        key_n = 1'b0;
        #3 rst_n = 1'b0;
        #1;
        chk("midrst_ledr", ledr, 4'b0001);
        chk("midrst_op_a", op_a, 0);
        chk("midrst_valid", result_valid, 0);
        chk("midrst_result", result, 0);
        phase_b = 1'b0; exp_ledr = 4'b0001; have_res = 1'b0;
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        cycles(20);
        chk("held_key_ignored", ledr, 4'b0001);
        chk("held_key_op_a", op_a, 0);
        key_n = 1'b1;
        cycles(8);
        do_press(5'b0_1001);
        do_press(5'b1_0011);

        cycles(5);
        chk("scoreboard_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global time bound
    initial begin
        #500000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule

// File: doc/operand_entry_ctrl.md
# operand_entry_ctrl

Sequential operand-entry and result-capture controller for the 4-bit add/subtract datapath. It sits between the board pushbutton/switches and the combinational ripple adder. The raw button is debounced and each press captures operand A, then operand B plus the add/subtract mode. The controller drives the adder inputs and carry-in, then registers the adder's sum, carry-out and signed overflow for display. The adder takes the driven operands; this block takes its result back.

## Interface
Parameters:
- DEBOUNCE_CYCLES, 500000, consecutive synchronized cycles of stable level required to accept a press or release (10 ms at 50 MHz); minimum 2.

Ports:
- MAX10_CLK1_50  in  1  system clock, all state on rising edge
- RESET_N  in  1  asynchronous, active-low reset
- KEY0_N  in  1  raw pushbutton, active-low, asynchronous to clock, bouncy
- SW  in  5  SW[3:0] operand value, SW[4] mode (0 add, 1 subtract)
- adder_sum  in  4  sum from external adder (combinational from op_a/op_b/carry_in)
- adder_cout  in  1  carry-out from external adder
- op_a  out  4  registered operand A to adder
- op_b  out  4  registered operand B to adder, already inverted when subtracting
- carry_in  out  1  registered adder carry-in (= mode)
- result  out  4  registered sum
- result_cout  out  1  registered carry-out
- result_ovf  out  1  registered two's-complement overflow
- result_valid  out  1  high while result/result_cout/result_ovf hold a completed operation
- LEDR  out  4  one-hot state: 0001 GET_A, 0010 GET_B, 0100 EXEC, 1000 SHOW

## Operation
- Reset (RESET_N low, asynchronous): state GET_A, every output register 0, LEDR=0001, debounce counter 0, debouncer in WAIT_RELEASE.
- Input path: KEY0_N passes through a 2-flop synchronizer. The debouncer has two states, WAIT_RELEASE and ARMED.
  - WAIT_RELEASE: counts consecutive high cycles and moves to ARMED at DEBOUNCE_CYCLES. Any low resets the count.
  - ARMED: counts consecutive low cycles. At DEBOUNCE_CYCLES it emits a one-cycle press pulse and returns to WAIT_RELEASE. Any high resets the count.
  - Result: exactly one pulse per press. A button held through reset deassertion is ignored until released and re-pressed.
- GET_A: on press, a_reg<=SW[3:0], op_a<=SW[3:0]; go to GET_B.
- GET_B: on press, op_b<=SW[4] ? ~SW[3:0] : SW[3:0], carry_in<=SW[4]; go to EXEC.
- EXEC: exactly one cycle.
  - At its closing edge: result<=adder_sum, result_cout<=adder_cout, result_ovf<=(op_a[3]==op_b[3]) && (adder_sum[3]!=op_a[3]), result_valid<=1.
  - Go to SHOW. A press pulse arriving in EXEC is dropped.
- SHOW: hold all outputs.
  - On press: op_a<=SW[3:0], result_valid<=0 (same edge), go to GET_B.
  - result, result_cout and result_ovf keep their old values until the next EXEC.
- SW is sampled only on a press edge. Changes at any other time have no effect.
- Arithmetic is 4-bit modulo. Subtraction is A + ~B + 1. Carry-out in subtract mode means no borrow.

## Timing
- Raw KEY0_N fall (clean, held) to capture edge: DEBOUNCE_CYCLES+2 to DEBOUNCE_CYCLES+3 clock edges.
- Press pulse width: exactly 1 cycle. Minimum press-to-press spacing: 2×DEBOUNCE_CYCLES cycles.
- GET_B capture to result_valid high: 2 edges (EXEC entry, then EXEC exit). LEDR reads 0100 for exactly one cycle.
- op_a, op_b and carry_in are stable throughout EXEC. The adder must settle within one clock period.
- RESET_N assertion mid-operation, in any state, forces the reset values immediately (asynchronous). Deassertion takes effect at the next edge.

## Test plan
Bench models the adder combinationally and sets DEBOUNCE_CYCLES=4.
- Reset with KEY0_N high -> all outputs 0, LEDR=0001, result_valid=0. No capture until a full release-then-press sequence.
- Add: press with SW=0_0011, then press with SW=0_0100 -> op_b=0100, carry_in=0. Two edges later: result=0111, result_cout=0, result_ovf=0, result_valid=1, LEDR=1000.
- Subtract 5-7: SW=0_0101, then SW=1_0111 -> op_b=1000, carry_in=1, result=1110, result_cout=0, result_ovf=0.
- Overflow cases:
  - 7+1 (0_0111, 0_0001) -> result=1000, result_ovf=1, result_cout=0.
  - −8−1 (0_1000, 1_0001) -> op_b=1110, result=0111, result_cout=1, result_ovf=1.
- Bounce: low glitches of 1–3 cycles separated by highs -> no capture, LEDR stays 0001. A clean 20-cycle low -> exactly one capture. A second press in SHOW -> result_valid falls on the capture edge and LEDR=0010.
- Reset mid-operation: assert RESET_N low while in GET_B with KEY0_N held low, then release reset -> LEDR=0001, op_a=0. No capture while key stays low. Capture occurs only after ≥4 high cycles followed by ≥4 low cycles.
